// File: rtl/reg_bank_scan_pkg.sv
// Shared definitions for the reg_bank_scan storage bank.
//   - scan_state_e   : scan FSM states (StParity is only reached when the parity
//                      option REG_BANK_SCAN_PARITY_EN is compiled in)
//   - DefChannels    : default number of storage channels
//   - DefWidth       : default bits per channel
//   - scan_cnt_width : width of the scan bit counter for an N-bit scan
package reg_bank_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } scan_state_e;

    localparam int unsigned DefChannels = 4;
    localparam int unsigned DefWidth    = 4;

    // The counter must be able to hold N itself.
    function automatic int unsigned scan_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reg_bank_scan_chan.sv
// One storage channel of reg_bank_scan.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, loads Init
//   d_i      : write data
//   en_i     : effective (already polarity-corrected) write enable
//   sr_i     : effective synchronous set/reset, has priority over en_i
//   q_o      : channel output, transparent to d_i in latch-emulation mode
//   stored_o : registered value, never bypassed (used for scan capture)
module reg_bank_chan #(
    parameter int unsigned      Width     = 4,
    parameter logic [Width-1:0] Init      = '0,
    parameter logic [Width-1:0] SrVal     = '0,
    parameter bit               ModeLatch = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    input  logic             en_i,
    input  logic             sr_i,
    output logic [Width-1:0] q_o,
    output logic [Width-1:0] stored_o
);

    logic [Width-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (sr_i) begin
            data_d = SrVal;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= Init;
        end else begin
            data_q <= data_d;
        end
    end

    // Latch emulation: transparent while enabled; the edge capture above keeps
    // the last d once the enable drops.
    always_comb begin
        q_o = data_q;
        if (ModeLatch && en_i && !sr_i) begin
            q_o = d_i;
        end
    end

    assign stored_o = data_q;

endmodule

// File: rtl/reg_bank_scan.sv
// reg_bank_scan: parametrised multi-channel storage bank with serial scan-out.
// Optional feature macro: REG_BANK_SCAN_PARITY_EN appends an even-parity bit
// after the data bits of every scan.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (storage=INIT, scan aborted)
//   d          : write data, broadcast to all channels
//   en         : per-channel write enable, before EN_INV
//   sr         : synchronous set/reset, before SR_INV
//   q          : channel outputs, channel c at [c*WIDTH +: WIDTH]
//   scan_start : request a scan-out (ignored while busy)
//   scan_busy  : scan in progress
//   scan_valid : scan_out carries a bit
//   scan_out   : serial data, channel 0 LSB first
//   scan_done  : one-cycle pulse on the final scan bit
module reg_bank_scan
    import reg_bank_pkg::*;
#(
    parameter int unsigned                CHANNELS   = DefChannels,
    parameter int unsigned                WIDTH      = DefWidth,
    parameter logic [CHANNELS*WIDTH-1:0] INIT       = 16'hA5C3,
    parameter logic [CHANNELS*WIDTH-1:0] SR_VAL     = 16'h0000,
    parameter bit                         SR_INV     = 1'b0,
    parameter logic [CHANNELS-1:0]        EN_INV     = 4'b0000,
    parameter logic [CHANNELS-1:0]        MODE_LATCH = 4'b0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          d,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      sr,
    output logic [CHANNELS*WIDTH-1:0] q,
    input  logic                      scan_start,
    output logic                      scan_busy,
    output logic                      scan_valid,
    output logic                      scan_out,
    output logic                      scan_done
);

    localparam int unsigned     N       = CHANNELS * WIDTH;
    localparam int unsigned     CntW    = scan_cnt_width(N);
    localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

    logic                sr_eff;
    logic [CHANNELS-1:0] en_eff;
    logic [N-1:0]        stored;

    assign sr_eff = sr ^ SR_INV;
    assign en_eff = en ^ EN_INV;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        reg_bank_chan #(
            .Width     (WIDTH),
            .Init      (INIT[c*WIDTH +: WIDTH]),
            .SrVal     (SR_VAL[c*WIDTH +: WIDTH]),
            .ModeLatch (MODE_LATCH[c])
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .d_i      (d),
            .en_i     (en_eff[c]),
            .sr_i     (sr_eff),
            .q_o      (q[c*WIDTH +: WIDTH]),
            .stored_o (stored[c*WIDTH +: WIDTH])
        );
    end

    // Scan FSM
    scan_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    shift_q, shift_d;
`ifdef REG_BANK_SCAN_PARITY_EN
    logic            par_q, par_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        scan_busy  = 1'b0;
        scan_valid = 1'b0;
        scan_out   = 1'b0;
        scan_done  = 1'b0;
`ifdef REG_BANK_SCAN_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (scan_start) begin
                    // Registered values only: latch bypass never reaches the scan.
                    shift_d = stored;
                    cnt_d   = '0;
                    state_d = StShift;
`ifdef REG_BANK_SCAN_PARITY_EN
                    par_d   = ^stored;
`endif
                end
            end
            StShift: begin
                scan_busy  = 1'b1;
                scan_valid = 1'b1;
                scan_out   = shift_q[0];
                shift_d    = shift_q >> 1;
                cnt_d      = cnt_q + CntW'(1);
                if (cnt_q == LastIdx) begin
`ifdef REG_BANK_SCAN_PARITY_EN
                    state_d   = StParity;
`else
                    scan_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
`endif
                end
            end
`ifdef REG_BANK_SCAN_PARITY_EN
            StParity: begin
                scan_busy  = 1'b1;
                scan_valid = 1'b1;
                scan_out   = par_q;
                scan_done  = 1'b1;
                cnt_d      = '0;
                state_d    = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

`ifdef REG_BANK_SCAN_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_reg_bank_scan.sv
// Self-checking bench for reg_bank_scan. Three instances share clock, reset,
// data and scan_start:
//   u_def : all default parameters
//   u_sr  : SR_VAL=16'h0F0F
//   u_alt : EN_INV=4'b0010, SR_INV=1, SR_VAL=16'h0F0F, MODE_LATCH=4'b0001
module tb_reg_bank_scan;

`ifdef REG_BANK_SCAN_PARITY_EN
    localparam int NBits = 17;
`else
    localparam int NBits = 16;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  d;
    logic [3:0]  en;
    logic        sr;
    logic [3:0]  en_a;
    logic        sr_a;
    logic        scan_start;
    logic [15:0] q_def, q_sr, q_alt;
    logic [2:0]  busy, valid, sout, done;

    int n_cmp  = 0;
    int n_fail = 0;

    reg_bank_scan u_def (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .sr(sr), .q(q_def),
        .scan_start(scan_start), .scan_busy(busy[0]), .scan_valid(valid[0]),
        .scan_out(sout[0]), .scan_done(done[0])
    );

    reg_bank_scan #(.SR_VAL(16'h0F0F)) u_sr (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .sr(sr), .q(q_sr),
        .scan_start(scan_start), .scan_busy(busy[1]), .scan_valid(valid[1]),
        .scan_out(sout[1]), .scan_done(done[1])
    );

    reg_bank_scan #(
        .SR_VAL(16'h0F0F), .SR_INV(1'b1), .EN_INV(4'b0010), .MODE_LATCH(4'b0001)
    ) u_alt (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en_a), .sr(sr_a), .q(q_alt),
        .scan_start(scan_start), .scan_busy(busy[2]), .scan_valid(valid[2]),
        .scan_out(sout[2]), .scan_done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] d;
        logic [3:0] en;
        logic       sr;
        logic [3:0] en_a;
        logic       sr_a;
        logic [15:0] exp_def;
        logic [15:0] exp_sr;
        logic [15:0] exp_alt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Idle: no enables, no set/reset on any instance (u_alt has inverted polarities).
    task automatic idle_inputs();
        d    = 4'h0;
        en   = 4'b0000;
        sr   = 1'b0;
        en_a = 4'b0010;
        sr_a = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        scan_start = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_scan(input bit abort);
        logic [16:0] exp_bits;
        bit          aborted;
        exp_bits = {1'b0, 16'hA5C3};  // parity of A5C3 is even -> 0
        aborted  = 1'b0;
        scan_start = 1'b1;
        for (int k = 0; k < NBits; k++) begin
            @(negedge clk);
            scan_start = 1'b0;
            check($sformatf("scan_valid[%0d]", k), {29'd0, valid}, 32'h7);
            check($sformatf("scan_busy[%0d]", k), {29'd0, busy}, 32'h7);
            check($sformatf("scan_out[%0d]", k), {29'd0, sout}, {29'd0, {3{exp_bits[k]}}});
            check($sformatf("scan_done[%0d]", k), {29'd0, done},
                  (k == NBits - 1) ? 32'h7 : 32'h0);
            if (abort) begin
                if (k == 5) begin
                    rst_n = 1'b0;
                    #1;
                    check("abort_valid", {29'd0, valid}, 32'h0);
                    check("abort_busy", {29'd0, busy}, 32'h0);
                    check("abort_done", {29'd0, done}, 32'h0);
                    check("abort_q_def", {16'd0, q_def}, 32'hA5C3);
                    check("abort_q_alt", {16'd0, q_alt}, 32'hA5C3);
                    @(negedge clk);
                    check("abort_done_after", {29'd0, done}, 32'h0);
                    rst_n = 1'b1;
                    aborted = 1'b1;
                    break;
                end
            end else begin
                // Write mid-scan must not disturb the captured stream.
                if (k == 3) begin
                    en = 4'hF;
                    d  = 4'h0;
                end
                if (k == 4) begin
                    en = 4'h0;
                end
                // Start request while busy is dropped.
                if (k == 6) scan_start = 1'b1;
            end
            // Start during the scan_done cycle is ignored too.
            if (k == NBits - 1) scan_start = 1'b1;
        end
        if (!aborted) begin
            @(negedge clk);
            scan_start = 1'b0;
            check("post_valid", {29'd0, valid}, 32'h0);
            check("post_busy", {29'd0, busy}, 32'h0);
            check("post_done", {29'd0, done}, 32'h0);
            @(negedge clk);
            check("no_restart_valid", {29'd0, valid}, 32'h0);
            if (!abort) begin
                check("scan_write_q_def", {16'd0, q_def}, 32'h0000);
                check("scan_write_q_sr", {16'd0, q_sr}, 32'h0000);
                check("scan_write_q_alt", {16'd0, q_alt}, 32'hA5C3);
            end
        end
    endtask

    initial begin
        vecs[0] = '{"write_ch1", 4'hF, 4'b0010, 1'b0, 4'b0000, 1'b1, 16'hA5F3, 16'hA5F3, 16'hA5F3};
        vecs[1] = '{"sr_prio",   4'h6, 4'b1111, 1'b1, 4'b1101, 1'b0, 16'h0000, 16'h0F0F, 16'h0F0F};
        vecs[2] = '{"write_all", 4'h7, 4'b1111, 1'b0, 4'b1101, 1'b1, 16'h7777, 16'h7777, 16'h7777};
        vecs[3] = '{"hold",      4'hE, 4'b0000, 1'b0, 4'b0010, 1'b1, 16'h7777, 16'h7777, 16'h7777};
        vecs[4] = '{"write_ch3", 4'h2, 4'b1000, 1'b0, 4'b1010, 1'b1, 16'h2777, 16'h2777, 16'h2777};

        rst_n = 1'b0;
        scan_start = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("rst_q_def", {16'd0, q_def}, 32'hA5C3);
        check("rst_q_sr", {16'd0, q_sr}, 32'hA5C3);
        check("rst_q_alt", {16'd0, q_alt}, 32'hA5C3);
        check("rst_busy", {29'd0, busy}, 32'h0);
        check("rst_valid", {29'd0, valid}, 32'h0);
        check("rst_out", {29'd0, sout}, 32'h0);
        check("rst_done", {29'd0, done}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            d    = vecs[i].d;
            en   = vecs[i].en;
            sr   = vecs[i].sr;
            en_a = vecs[i].en_a;
            sr_a = vecs[i].sr_a;
            @(negedge clk);
            check({vecs[i].name, "_def"}, {16'd0, q_def}, {16'd0, vecs[i].exp_def});
            check({vecs[i].name, "_sr"}, {16'd0, q_sr}, {16'd0, vecs[i].exp_sr});
            check({vecs[i].name, "_alt"}, {16'd0, q_alt}, {16'd0, vecs[i].exp_alt});
        end

        // Latch emulation on u_alt channel 0 (state 2777 everywhere).
        idle_inputs();
        d    = 4'h9;
        en_a = 4'b0011;
        #1;
        check("latch_bypass_alt", {16'd0, q_alt}, 32'h2779);
        check("latch_bypass_def", {16'd0, q_def}, 32'h2777);
        @(negedge clk);
        en_a = 4'b0010;
        d    = 4'h2;
        #1;
        check("latch_hold_alt", {16'd0, q_alt}, 32'h2779);
        check("latch_hold_def", {16'd0, q_def}, 32'h2777);

        do_reset();
        do_scan(1'b0);
        do_reset();
        do_scan(1'b1);
        do_scan(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
